// File: rtl/entrada_botoes.sv
`default_nettype none
// ============================================================================
//  Module   : entrada_botoes
//  Purpose  : Synchronizes and debounces the 9 board buttons and accepts
//             exactly one press per press/release cycle. It emits a one-cycle
//             tem_jogada pulse and holds the one-hot/index of the chosen cell.
//  Option   : define MULTI_ERRO_EN to flag multi-button presses on
//             erro_multipla instead of accepting the lowest-index cell.
//  Revision : 1.0 - initial release
// ============================================================================
module entrada_botoes #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [8:0] botoes,
  input  logic       habilita,
  output logic       tem_jogada,
  output logic [8:0] jogada,
  output logic [3:0] indice,
`ifdef MULTI_ERRO_EN
  output logic       erro_multipla,
`endif
  output logic [3:0] db_estado
);

  localparam logic [1:0] OCIOSO = 2'd0;
  localparam logic [1:0] FILTRA = 2'd1;
  localparam logic [1:0] VALIDA = 2'd2;
  localparam logic [1:0] SOLTA  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ALVO = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_UM   = CNT_W'(1);

  logic [8:0]       sync_a;
  logic [8:0]       s;
  logic [1:0]       estado;
  logic [8:0]       padrao;
  logic [CNT_W-1:0] cnt;

  // Binary index of the lowest set bit; 4'hF when nothing is set.
  function automatic logic [3:0] indice_menor(input logic [8:0] p);
    logic [3:0] r;
    r = 4'hF;
    for (int i = 8; i >= 0; i--) begin
      if (p[i]) r = 4'(i);
    end
    return r;
  endfunction

  // Isolates the lowest set bit as a one-hot vector.
  function automatic logic [8:0] onehot_menor(input logic [8:0] p);
    return p & (~p + 9'd1);
  endfunction

  // Two-flop synchronizer; every decision below uses s only.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_a <= '0;
      s      <= '0;
    end else begin
      sync_a <= botoes;
      s      <= sync_a;
    end
  end

  // Debounce/accept state machine; outputs are set on the edge entering VALIDA.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado     <= SOLTA;
      cnt        <= '0;
      padrao     <= '0;
      tem_jogada <= 1'b0;
      jogada     <= '0;
      indice     <= 4'hF;
`ifdef MULTI_ERRO_EN
      erro_multipla <= 1'b0;
`endif
    end else begin
      tem_jogada <= 1'b0;
`ifdef MULTI_ERRO_EN
      erro_multipla <= 1'b0;
`endif
      case (estado)
        OCIOSO: begin
          if (s != '0 && habilita) begin
            padrao <= s;
            cnt    <= CNT_UM;
            estado <= FILTRA;
          end
        end
        FILTRA: begin
          if (!habilita || s == '0) begin
            estado <= OCIOSO;
          end else if (s != padrao) begin
            // A changing pattern is still bouncing: restart the window.
            padrao <= s;
            cnt    <= CNT_UM;
          end else if (cnt == CNT_ALVO) begin
            estado <= VALIDA;
`ifdef MULTI_ERRO_EN
            if ((padrao & (padrao - 9'd1)) != '0) begin
              erro_multipla <= 1'b1;
            end else begin
              tem_jogada <= 1'b1;
              jogada     <= onehot_menor(padrao);
              indice     <= indice_menor(padrao);
            end
`else
            tem_jogada <= 1'b1;
            jogada     <= onehot_menor(padrao);
            indice     <= indice_menor(padrao);
`endif
          end else begin
            cnt <= cnt + CNT_UM;
          end
        end
        VALIDA: begin
          estado <= SOLTA;
          cnt    <= '0;
        end
        SOLTA: begin
          // Any nonzero sample restarts the release window.
          if (s == '0) begin
            if (cnt == CNT_ALVO) begin
              estado <= OCIOSO;
            end else begin
              cnt <= cnt + CNT_UM;
            end
          end else begin
            cnt <= '0;
          end
        end
        default: begin
          estado <= SOLTA;
          cnt    <= '0;
        end
      endcase
    end
  end

  assign db_estado = {2'b00, estado};

endmodule
`default_nettype wire

// File: tb/tb_entrada_botoes.sv
`default_nettype none
// ============================================================================
//  Module   : tb_entrada_botoes
//  Purpose  : Self-checking bench for entrada_botoes: directed scenarios with
//             literal expectations plus randomized stimulus, all compared
//             every cycle against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_entrada_botoes;

  localparam int D = 4;
`ifdef MULTI_ERRO_EN
  localparam bit MULTI = 1'b1;
`else
  localparam bit MULTI = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic [8:0] botoes;
  logic       habilita;
  logic       tem_jogada;
  logic [8:0] jogada;
  logic [3:0] indice;
  logic       erro_multipla;
  logic [3:0] db_estado;

  always #5 clock = ~clock;

  entrada_botoes #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .botoes     (botoes),
    .habilita   (habilita),
    .tem_jogada (tem_jogada),
    .jogada     (jogada),
    .indice     (indice),
`ifdef MULTI_ERRO_EN
    .erro_multipla(erro_multipla),
`endif
    .db_estado  (db_estado)
  );

`ifndef MULTI_ERRO_EN
  assign erro_multipla = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         cyc = 0;
  bit         model_valid = 1'b0;
  logic [8:0] h1, h2, sv;
  bit         waiting_release;
  bit         accept_cycle;
  int         zero_run;
  int         run;
  logic [8:0] pat;
  bit         exp_tem, exp_err;
  logic [8:0] exp_jog;
  logic [3:0] exp_idx;
  logic [3:0] exp_state;

  always @(posedge clock) begin
    cyc++;
    sv = h2;
    exp_tem = 1'b0;
    exp_err = 1'b0;
    if (reset) begin
      model_valid     = 1'b1;
      waiting_release = 1'b1;
      accept_cycle    = 1'b0;
      zero_run        = 0;
      run             = 0;
      pat             = '0;
      exp_jog         = '0;
      exp_idx         = 4'hF;
      h1              = '0;
      h2              = '0;
    end else begin
      if (accept_cycle) begin
        accept_cycle    = 1'b0;
        waiting_release = 1'b1;
        zero_run        = 0;
      end else if (waiting_release) begin
        if (sv == 0) begin
          if (zero_run == D) waiting_release = 1'b0;
          else zero_run++;
        end else begin
          zero_run = 0;
        end
      end else if (run == 0) begin
        if (sv != 0 && habilita) begin
          pat = sv;
          run = 1;
        end
      end else begin
        if (!habilita || sv == 0) run = 0;
        else if (sv != pat) begin
          pat = sv;
          run = 1;
        end else if (run == D) begin
          run = 0;
          accept_cycle = 1'b1;
          if (MULTI && $countones(pat) > 1) exp_err = 1'b1;
          else begin
            exp_tem = 1'b1;
            exp_jog = pat & (~pat + 9'd1);
            exp_idx = 4'($clog2(exp_jog));
          end
        end else run++;
      end
      h2 = h1;
      h1 = botoes;
    end
    exp_state = waiting_release ? 4'd3 : accept_cycle ? 4'd2 : (run > 0) ? 4'd1 : 4'd0;
  end

  // ---------------- per-cycle compare ----------------
  int pulse_cnt  = 0;
  int err_cnt    = 0;
  int pulse_edge = -1;

  always @(negedge clock) begin
    if (model_valid) begin
      chk("tem_jogada", 32'(tem_jogada), 32'(exp_tem));
      chk("erro_multipla", 32'(erro_multipla), 32'(exp_err));
      chk("jogada", 32'(jogada), 32'(exp_jog));
      chk("indice", 32'(indice), 32'(exp_idx));
      chk("db_estado", 32'(db_estado), 32'(exp_state));
      chk("pulse_and_error_exclusive", 32'(tem_jogada & erro_multipla), 32'd0);
      if (tem_jogada === 1'b1) begin
        pulse_cnt++;
        pulse_edge = cyc;
      end
      if (erro_multipla === 1'b1) err_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  int         p0, e0, k, idle_edge, r;
  logic [8:0] v;

  initial begin
    reset    = 1'b1;
    botoes   = '0;
    habilita = 1'b1;
    step(3);
    reset = 1'b0;
    chk("reset_db_estado", 32'(db_estado), 32'd3);
    chk("reset_indice", 32'(indice), 32'hF);
    chk("reset_jogada", 32'(jogada), 32'd0);
    chk("reset_tem_jogada", 32'(tem_jogada), 32'd0);
    step(10);
    chk("idle_after_release", 32'(db_estado), 32'd0);

    // clean press of cell 4
    p0 = pulse_cnt;
    k = cyc + 1;
    botoes = 9'b000010000;
    step(20);
    chk("t1_one_pulse", 32'(pulse_cnt - p0), 32'd1);
    chk("t1_latency", 32'(pulse_edge), 32'(k + 6));
    chk("t1_jogada", 32'(jogada), 32'b000010000);
    chk("t1_indice", 32'(indice), 32'd4);
    botoes = '0;
    step(12);

    // bouncing cell 2
    p0 = pulse_cnt;
    for (int i = 0; i < 10; i++) begin
      v = (((i / 2) % 2) == 0) ? 9'h004 : 9'h000;
      if (v != botoes) k = cyc + 1;
      botoes = v;
      step(1);
    end
    chk("t2_no_pulse_bouncing", 32'(pulse_cnt - p0), 32'd0);
    step(15);
    chk("t2_one_pulse", 32'(pulse_cnt - p0), 32'd1);
    chk("t2_latency", 32'(pulse_edge), 32'(k + 6));
    chk("t2_indice", 32'(indice), 32'd2);
    botoes = '0;
    step(12);

    // button held through reset
    reset = 1'b1;
    botoes = 9'h001;
    step(2);
    reset = 1'b0;
    p0 = pulse_cnt;
    step(10);
    chk("t3_no_pulse_held_reset", 32'(pulse_cnt - p0), 32'd0);
    botoes = '0;
    step(10);
    k = cyc + 1;
    botoes = 9'h001;
    step(12);
    chk("t3_repress_pulse", 32'(pulse_cnt - p0), 32'd1);
    chk("t3_latency", 32'(pulse_edge), 32'(k + 6));
    chk("t3_indice", 32'(indice), 32'd0);
    botoes = '0;
    step(12);

    // habilita gating
    habilita = 1'b0;
    botoes = 9'h020;
    p0 = pulse_cnt;
    step(10);
    chk("t4_no_pulse_hab0", 32'(pulse_cnt - p0), 32'd0);
    chk("t4_idle_hab0", 32'(db_estado), 32'd0);
    habilita = 1'b1;
    k = cyc + 1;
    step(12);
    chk("t4_pulse_after_hab", 32'(pulse_cnt - p0), 32'd1);
    chk("t4_latency", 32'(pulse_edge), 32'(k + 4));
    chk("t4_indice", 32'(indice), 32'd5);
    botoes = '0;
    step(12);
    p0 = pulse_cnt;
    botoes = 9'h080;
    step(4);
    chk("t4_in_filtra", 32'(db_estado), 32'd1);
    habilita = 1'b0;
    step(8);
    chk("t4_abort_no_pulse", 32'(pulse_cnt - p0), 32'd0);
    botoes = '0;
    habilita = 1'b1;
    step(12);

    // multi-button press
    p0 = pulse_cnt;
    e0 = err_cnt;
    botoes = 9'b100000100;
    step(12);
`ifdef MULTI_ERRO_EN
    chk("t5_no_pulse_multi", 32'(pulse_cnt - p0), 32'd0);
    chk("t5_error_pulse", 32'(err_cnt - e0), 32'd1);
    chk("t5_indice_kept", 32'(indice), 32'd5);
    chk("t5_jogada_kept", 32'(jogada), 32'h020);
`else
    chk("t5_pulse_multi", 32'(pulse_cnt - p0), 32'd1);
    chk("t5_indice_lowest", 32'(indice), 32'd2);
    chk("t5_jogada_lowest", 32'(jogada), 32'h004);
`endif
    botoes = '0;
    step(12);

    // release glitch
    p0 = pulse_cnt;
    botoes = 9'h080;
    step(10);
    botoes = '0;
    step(2);
    botoes = 9'h080;
    step(1);
    botoes = '0;
    k = cyc + 1;
    idle_edge = -1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (db_estado == 4'd0) begin
        idle_edge = cyc;
        break;
      end
    end
    chk("t6_idle_edge", 32'(idle_edge), 32'(k + 6));
    chk("t6_single_pulse", 32'(pulse_cnt - p0), 32'd1);
    chk("t6_indice", 32'(indice), 32'd7);
    step(4);

    // randomized traffic
    p0 = pulse_cnt;
    for (int n = 0; n < 1200; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6) v = 9'd1 << $urandom_range(0, 8);
      else if (r < 8) v = '0;
      else v = 9'($urandom);
      botoes   = v;
      habilita = ($urandom_range(0, 9) != 0);
      reset    = ($urandom_range(0, 199) == 0);
      step(int'($urandom_range(1, 12)));
    end
    reset = 1'b0;
    botoes = '0;
    step(12);
    chk("rnd_some_pulses", 32'(pulse_cnt > p0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/entrada_botoes.md
Name: entrada_botoes

Overview:
Input-conditioning stage directly upstream of the game circuit. It synchronizes and debounces the 9 board buttons and accepts exactly one press per press/release cycle. It emits a one-cycle tem_jogada pulse plus a held one-hot and index encoding of the chosen cell, ready to feed the registers for the macro/micro board positions. An accepted press is never repeated until every button has been stably released.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronized cycles a pattern must be stable to be accepted (press) or to count as released; legal range 2..65535.
CNT_W, 16, width of the internal stability counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
clock  in  1  system clock; every register updates on the rising edge.
reset  in  1  synchronous, active-high reset.
botoes  in  9  raw asynchronous buttons, active-high; bit i = cell i (0..8).
habilita  in  1  high = presses may be accepted (control unit is waiting for a move).
tem_jogada  out  1  one-cycle pulse when a press is accepted.
jogada  out  9  one-hot accepted cell; held until the next accept.
indice  out  4  binary index 0..8 of the accepted cell; held until the next accept.
erro_multipla  out  1  one-cycle pulse on a multi-button press (present only with MULTI_ERRO_EN).
db_estado  out  4  current state code, for the 7-segment debug display.

Behaviour:
- Clock/reset: single clock domain; reset is synchronous and active-high.
- Reset values: state=SOLTA, cnt=0, tem_jogada=0, jogada=9'b0, indice=4'hF, erro_multipla=0, sync flops=0.
- Synchronizer: two-flop synchronizer per bit, giving s = botoes delayed 2 cycles. All FSM decisions use s only.
- States and db_estado codes: OCIOSO=0, FILTRA=1, VALIDA=2, SOLTA=3. Any other code returns to SOLTA.
- OCIOSO:
  - If s!=0 and habilita=1: padrao<=s, cnt<=1, go to FILTRA.
  - Otherwise stay.
- FILTRA:
  - If habilita=0 or s==0: go to OCIOSO.
  - Else if s!=padrao: padrao<=s, cnt<=1, stay (restart filtering).
  - Else if cnt==DEBOUNCE_CYCLES: go to VALIDA.
  - Else cnt++.
- VALIDA (one cycle):
  - tem_jogada=1 for exactly this cycle.
  - jogada/indice are updated on the edge entering VALIDA, so they are valid while the pulse is high.
  - Selection: the lowest set bit of padrao.
  - Next state: SOLTA, with cnt<=0.
- SOLTA:
  - If s==0: cnt++.
  - If s!=0: cnt<=0.
  - When cnt reaches DEBOUNCE_CYCLES with s==0: go to OCIOSO.
  - habilita is ignored in this state.
- Latency: a clean press first sampled at edge k makes tem_jogada high in the cycle after edge k+2+DEBOUNCE_CYCLES (7 edges for the default of 4).
- Buttons held at or during reset: never accepted. The block starts in SOLTA, so a full stable release is required first.
- Bounce during FILTRA (pattern change): restarts the count; never yields two pulses.
- A button still held after acceptance: produces no further pulses.
- Adding a second button after acceptance: produces no further pulses.
- habilita falling during FILTRA: aborts with no pulse.
- habilita falling on the VALIDA cycle: the pulse still completes.
- Reset in any state: overrides everything on that edge.
- tem_jogada and erro_multipla: never high in the same cycle.

Optional Feature:
MULTI_ERRO_EN
- Defined:
  - Port erro_multipla exists.
  - Entering VALIDA with popcount(padrao)>1 gives erro_multipla=1 for one cycle, tem_jogada=0, jogada/indice unchanged, then SOLTA.
- Undefined:
  - The port is absent.
  - Multi-bit patterns are accepted with lowest-index priority as above.

Test Plan:
- Reset then clean hold of botoes=9'b000010000 for 20 cycles, habilita=1 -> exactly one tem_jogada pulse, 7 edges after the first sample; jogada=9'b000010000, indice=4. No further pulses while held.
- Bit 2 toggles every 2 cycles for 10 cycles, then holds -> no pulse during the bouncing; one pulse DEBOUNCE_CYCLES+3 edges after the last edge; indice=2.
- Button 0 held through reset deassertion, released, then pressed again -> no pulse for the first hold; one pulse for the re-press; indice=0.
- Press with habilita=0, then habilita raised while still held -> pulse occurs only after habilita=1 plus a full filter window. Dropping habilita mid-FILTRA -> no pulse.
- botoes=9'b100000100 held: without the macro -> pulse, indice=2, jogada=9'b000000100. With MULTI_ERRO_EN -> erro_multipla pulse, no tem_jogada, indice keeps its previous value.
- Release glitch: after acceptance, botoes drops to 0 for 2 cycles, reasserts for 1 cycle, then releases -> no second pulse; state reaches OCIOSO only DEBOUNCE_CYCLES clean-zero cycles after the final release.
